// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - I2C target: address match, register pointer, byte write/read with auto-increment
// Optional 3-sample majority filter on SCL/SDA: define I2C_TARGET_GLITCH_FILTER_EN
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         REG_AW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_out_en,
  output logic              wr_en,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK,
    RDATA, RDATA_ACK, RDATA_NEXT, IGNORE
  } state_t;

  localparam logic [REG_AW-1:0] PTR_ONE = {{(REG_AW-1){1'b0}}, 1'b1};

  logic [1:0] scl_sync, sda_sync;
  logic       scl_cur, sda_cur, scl_hist, sda_hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_cur;
      sda_hist <= sda_cur;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_win, sda_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_win <= 3'b111;
      sda_win <= 3'b111;
    end else begin
      scl_win <= {scl_win[1:0], scl_sync[1]};
      sda_win <= {sda_win[1:0], sda_sync[1]};
    end
  end

  // 2-of-3 vote rejects any single-sample pulse
  assign scl_cur = (scl_win[0] & scl_win[1]) | (scl_win[0] & scl_win[2]) | (scl_win[1] & scl_win[2]);
  assign sda_cur = (sda_win[0] & sda_win[1]) | (sda_win[0] & sda_win[2]) | (sda_win[1] & sda_win[2]);
`else
  assign scl_cur = scl_sync[1];
  assign sda_cur = sda_sync[1];
`endif

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_cur & ~scl_hist;
  assign scl_fall  = ~scl_cur & scl_hist;
  assign start_det = scl_cur & sda_hist & ~sda_cur;
  assign stop_det  = scl_cur & ~sda_hist & sda_cur;

  state_t            state, state_nxt;
  logic [3:0]        bit_cnt, bit_cnt_nxt;
  logic [6:0]        shreg, shreg_nxt;
  logic [6:0]        tx, tx_nxt;
  logic [REG_AW-1:0] ptr, ptr_nxt;
  logic              rw, rw_nxt;
  logic              oe_nxt, wr_en_nxt, busy_nxt;
  logic [REG_AW-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic [7:0]        sda_byte;
  logic              last_bit;

  assign sda_byte = {shreg, sda_cur};
  assign last_bit = scl_rise && (bit_cnt == 4'd7);
  assign rd_addr  = ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 7'd0;
      tx         <= 7'd0;
      ptr        <= '0;
      rw         <= 1'b0;
      sda_out_en <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 8'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      tx         <= tx_nxt;
      ptr        <= ptr_nxt;
      rw         <= rw_nxt;
      sda_out_en <= oe_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      busy       <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    tx_nxt      = tx;
    ptr_nxt     = ptr;
    rw_nxt      = rw;
    oe_nxt      = sda_out_en;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    busy_nxt    = busy;

    if (stop_det) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = 4'd0;
      oe_nxt      = 1'b0;
      busy_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt   = ADDR;
      bit_cnt_nxt = 4'd0;
      oe_nxt      = 1'b0;
    end else begin
      case (state)
        IDLE: oe_nxt = 1'b0;

        ADDR, REG, WDATA: begin
          if (scl_rise) begin
            shreg_nxt   = sda_byte[6:0];
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
          if (last_bit) begin
            if (state == ADDR) begin
              if (sda_byte[7:1] == DEV_ADDR) begin
                state_nxt = ADDR_ACK;
                rw_nxt    = sda_byte[0];
                busy_nxt  = 1'b1;
              end else begin
                state_nxt = IGNORE;
                busy_nxt  = 1'b0;
              end
            end else if (state == REG) begin
              ptr_nxt   = REG_AW'(sda_byte);
              state_nxt = REG_ACK;
            end else begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = ptr;
              wr_data_nxt = sda_byte;
              state_nxt   = WDATA_ACK;
            end
          end
        end

        // First fall (8th) asserts the ACK, second fall (9th) ends it
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_out_en) begin
              oe_nxt = 1'b1;
            end else begin
              oe_nxt      = 1'b0;
              bit_cnt_nxt = 4'd0;
              if (state == ADDR_ACK && rw) begin
                state_nxt = RDATA;
                tx_nxt    = rd_data[6:0];
                oe_nxt    = ~rd_data[7];
              end else if (state == WDATA_ACK) begin
                ptr_nxt   = ptr + PTR_ONE;
                state_nxt = WDATA;
              end else if (state == ADDR_ACK) begin
                state_nxt = REG;
              end else begin
                state_nxt = WDATA;
              end
            end
          end
        end

        RDATA: begin
          if (scl_rise) begin
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              oe_nxt    = 1'b0;
              state_nxt = RDATA_ACK;
            end else begin
              oe_nxt = ~tx[6];
              tx_nxt = {tx[5:0], 1'b0};
            end
          end
        end

        // Pointer moves past every byte sent; a NACK ends the read
        RDATA_ACK: begin
          oe_nxt = 1'b0;
          if (scl_rise) begin
            ptr_nxt   = ptr + PTR_ONE;
            state_nxt = sda_cur ? IGNORE : RDATA_NEXT;
          end
        end

        RDATA_NEXT: begin
          if (scl_fall) begin
            tx_nxt      = rd_data[6:0];
            oe_nxt      = ~rd_data[7];
            bit_cnt_nxt = 4'd0;
            state_nxt   = RDATA;
          end
        end

        IGNORE: oe_nxt = 1'b0;

        default: begin
          state_nxt = IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

endmodule
